// File: rtl/wvb_readout_arbiter.sv
`timescale 1ns/1ps
// Round-robin readout of per-channel waveform buffers into one header+data valid/ready stream.
// Optional macro WVB_ARB_STATS_EN adds n_wvf_read, a saturating count of completed waveforms.
module wvb_readout_arbiter #(
    parameter int P_N_CHAN     = 24,
    parameter int P_CHAN_WIDTH = 5,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_LEN_WIDTH  = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [P_N_CHAN-1:0]              hdr_empty,
    input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_N_CHAN-1:0]              hdr_rdreq,
    output logic [P_N_CHAN-1:0]              wvb_rdreq,
    output logic [P_N_CHAN-1:0]              wvb_rddone,
    output logic [P_HDR_WIDTH-1:0]           out_data,
    output logic                             out_is_hdr,
    output logic                             out_last,
    output logic [P_CHAN_WIDTH-1:0]          out_chan,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
`ifdef WVB_ARB_STATS_EN
    ,
    output logic [31:0]                      n_wvf_read
`endif
);

    // state | meaning: IDLE disabled | SCAN pick channel | HDR pop header | HDRCAP take header
    //       | DATA stream words | DONE rddone, advance pointer
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_HDR, S_HDRCAP, S_DATA, S_DONE} state_t;

    localparam logic [P_N_CHAN-1:0] ONE_HOT0 = P_N_CHAN'(1);

    state_t                  state, state_nxt;
    logic [P_CHAN_WIDTH-1:0] grant, ptr, sel;
    logic                    found;
    logic [P_LEN_WIDTH-1:0]  cnt, hdr_len;
    logic                    inflight, inflight_last;
    logic                    hdr_req, wvb_req, done_pulse;

    logic [P_HDR_WIDTH-1:0]  sk_data [2];
    logic                    sk_hdr  [2];
    logic                    sk_last [2];
    logic [P_CHAN_WIDTH-1:0] sk_chan [2];
    logic                    rd_idx, wr_idx;
    logic [1:0]              occ;

    logic [P_HDR_WIDTH-1:0]  hdr_word, push_data;
    logic [P_DATA_WIDTH-1:0] wvb_word;
    logic                    push, push_hdr, push_last, pop, wr_en, rd_adv;

    // Two passes give the wrap: channels above the pointer first, then from 0 up to the pointer.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int c = P_N_CHAN-1; c >= 0; c--) begin
            if (!hdr_empty[c] && c > int'(ptr)) begin
                found = 1'b1;
                sel   = P_CHAN_WIDTH'(c);
            end
        end
        if (!found) begin
            for (int c = P_N_CHAN-1; c >= 0; c--) begin
                if (!hdr_empty[c] && c <= int'(ptr)) begin
                    found = 1'b1;
                    sel   = P_CHAN_WIDTH'(c);
                end
            end
        end
    end

    always_comb begin
        hdr_word = '0;
        wvb_word = '0;
        for (int c = 0; c < P_N_CHAN; c++) begin
            if (int'(grant) == c) begin
                hdr_word = hdr_data[c*P_HDR_WIDTH +: P_HDR_WIDTH];
                wvb_word = wvb_data[c*P_DATA_WIDTH +: P_DATA_WIDTH];
            end
        end
    end

    assign hdr_len = hdr_word[P_LEN_WIDTH-1:0];

    always_comb begin
        state_nxt  = state;
        hdr_req    = 1'b0;
        wvb_req    = 1'b0;
        done_pulse = 1'b0;
        case (state)
            S_IDLE:   if (en) state_nxt = S_SCAN;
            S_SCAN:   state_nxt = (en && found) ? S_HDR : S_IDLE;
            S_HDR: begin
                if (occ != 2'd2) begin
                    hdr_req   = 1'b1;
                    state_nxt = S_HDRCAP;
                end
            end
            S_HDRCAP: state_nxt = (hdr_len == '0) ? S_DONE : S_DATA;
            S_DATA: begin
                // Reads in flight are counted so a stalled sink never overflows the skid.
                if (cnt != '0 && (occ + {1'b0, inflight}) < 2'd2) begin
                    wvb_req = 1'b1;
                    if (cnt == P_LEN_WIDTH'(1)) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_pulse = 1'b1;
                state_nxt  = S_SCAN;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign push_hdr  = (state == S_HDRCAP);
    assign push      = push_hdr | inflight;
    assign push_last = push_hdr ? (hdr_len == '0) : (inflight & inflight_last);
    assign push_data = push_hdr ? hdr_word : (inflight ? P_HDR_WIDTH'(wvb_word) : '0);

    // An empty skid passes the incoming word straight through; it is stored only if not taken.
    always_comb begin
        if (occ != 2'd0) begin
            out_data   = sk_data[rd_idx];
            out_is_hdr = sk_hdr[rd_idx];
            out_last   = sk_last[rd_idx];
            out_chan   = sk_chan[rd_idx];
        end else begin
            out_data   = push_data;
            out_is_hdr = push_hdr;
            out_last   = push_last;
            out_chan   = grant;
        end
    end

    assign out_valid = (occ != 2'd0) || push;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !(occ == 2'd0 && out_ready);
    assign rd_adv    = pop && (occ != 2'd0);

    assign hdr_rdreq  = hdr_req    ? (ONE_HOT0 << grant) : '0;
    assign wvb_rdreq  = wvb_req    ? (ONE_HOT0 << grant) : '0;
    assign wvb_rddone = done_pulse ? (ONE_HOT0 << grant) : '0;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= '0;
            ptr           <= P_CHAN_WIDTH'(P_N_CHAN-1);
            cnt           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            rd_idx        <= 1'b0;
            wr_idx        <= 1'b0;
        end else begin
            state         <= state_nxt;
            if (state == S_SCAN && en && found) grant <= sel;
            if (done_pulse) ptr <= grant;
            if (push_hdr) cnt <= hdr_len;
            else if (wvb_req) cnt <= cnt - P_LEN_WIDTH'(1);
            inflight      <= wvb_req;
            inflight_last <= wvb_req && (cnt == P_LEN_WIDTH'(1));
            if (wr_en) wr_idx <= ~wr_idx;
            if (rd_adv) rd_idx <= ~rd_idx;
            occ           <= occ + {1'b0, wr_en} - {1'b0, rd_adv};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            sk_data[wr_idx] <= push_data;
            sk_hdr[wr_idx]  <= push_hdr;
            sk_last[wr_idx] <= push_last;
            sk_chan[wr_idx] <= grant;
        end
    end

`ifdef WVB_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            n_wvf_read <= '0;
        else if (done_pulse && n_wvf_read != 32'hFFFF_FFFF)
            n_wvf_read <= n_wvf_read + 32'd1;
    end
`endif

endmodule
